// File: rtl/instruction_encode_pkg.sv
// rtl/instruction_encode_pkg.sv - RV32I field widths, opcodes, type table and FSM states
package instruction_encode_pkg;

    localparam int OPCODE_WIDTH   = 7;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int FUNC3_WIDTH    = 3;
    localparam int FUNC7_WIDTH    = 7;
    localparam int DATA_WIDTH     = 32;
    localparam int INSTR_WIDTH    = 32;

    localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JAL    = 7'b1101111;

    localparam logic [FUNC3_WIDTH-1:0] F3_SLL     = 3'b001;
    localparam logic [FUNC3_WIDTH-1:0] F3_SRL_SRA = 3'b101;

    localparam logic [FUNC7_WIDTH-1:0] F7_ZERO = 7'h00;
    localparam logic [FUNC7_WIDTH-1:0] F7_SUB  = 7'h20;
    localparam logic [FUNC7_WIDTH-1:0] F7_SRA  = 7'h20;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        INSTR_TYPE_R,
        INSTR_TYPE_I,
        INSTR_TYPE_S,
        INSTR_TYPE_B,
        INSTR_TYPE_U,
        INSTR_TYPE_J,
        INSTR_TYPE_INVALID
    } instr_type_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } fill_state_t;

    // Same table the decode stage uses, so encode stays its exact inverse.
    function automatic instr_type_t opcode_type(input logic [OPCODE_WIDTH-1:0] opcode);
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: opcode_type = INSTR_TYPE_I;
            OPC_STORE:                      opcode_type = INSTR_TYPE_S;
            OPC_OP:                         opcode_type = INSTR_TYPE_R;
            OPC_BRANCH:                     opcode_type = INSTR_TYPE_B;
            OPC_LUI, OPC_AUIPC:             opcode_type = INSTR_TYPE_U;
            OPC_JAL:                        opcode_type = INSTR_TYPE_J;
            default:                        opcode_type = INSTR_TYPE_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/instruction_encode_if.sv
// rtl/instruction_encode_if.sv - decoded-field input stream and encoded-word output stream
interface instruction_encode_if;
    import instruction_encode_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [OPCODE_WIDTH-1:0]   in_opcode;
    logic [REG_ADDR_WIDTH-1:0] in_rd;
    logic [REG_ADDR_WIDTH-1:0] in_rs1;
    logic [REG_ADDR_WIDTH-1:0] in_rs2;
    logic [FUNC3_WIDTH-1:0]    in_func3;
    logic [FUNC7_WIDTH-1:0]    in_func7;
    logic [DATA_WIDTH-1:0]     in_imm;

    logic                      out_valid;
    logic                      out_ready;
    logic [INSTR_WIDTH-1:0]    out_instr;
    logic                      out_err;

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_func3, in_func7, in_imm,
        input  out_ready,
        output in_ready,
        output out_valid, out_instr, out_err
    );

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_func3, in_func7, in_imm,
        output out_ready,
        input  in_ready,
        input  out_valid, out_instr, out_err
    );

endinterface

// File: rtl/instruction_encode_instr_field_pack.sv
// rtl/instruction_encode_instr_field_pack.sv - combinational RV32I field packing and immediate range check
module instr_field_pack
    import instruction_encode_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0]   opcode,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    input  logic [FUNC3_WIDTH-1:0]    func3,
    input  logic [FUNC7_WIDTH-1:0]    func7,
    input  logic [DATA_WIDTH-1:0]     imm,
    output logic [INSTR_WIDTH-1:0]    word,
    output logic                      err
);

    instr_type_t            itype;
    logic                   is_shift;
    logic                   f7_alt_ok;
    logic [INSTR_WIDTH-1:0] raw;
    logic                   bad;

    assign itype     = opcode_type(opcode);
    assign is_shift  = (opcode == OPC_OP_IMM) && ((func3 == F3_SLL) || (func3 == F3_SRL_SRA));
    assign f7_alt_ok = (func7 == F7_ZERO) || (func7 == F7_SUB);

    // "All-equal" upper bits means the immediate survives truncation and sign-extension.
    always_comb begin
        raw = NOP_INSTR;
        bad = 1'b0;
        case (itype)
            INSTR_TYPE_R: begin
                raw = {func7, rs2, rs1, func3, rd, opcode};
                bad = !f7_alt_ok;
            end
            INSTR_TYPE_I: begin
                if (is_shift) begin
                    raw = {func7, imm[4:0], rs1, func3, rd, opcode};
                    bad = (|imm[31:5]) ||
                          ((func3 == F3_SLL) ? (func7 != F7_ZERO) : !f7_alt_ok);
                end else begin
                    raw = {imm[11:0], rs1, func3, rd, opcode};
                    bad = !((&imm[31:11]) || !(|imm[31:11]));
                end
            end
            INSTR_TYPE_S: begin
                raw = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
                bad = !((&imm[31:11]) || !(|imm[31:11]));
            end
            INSTR_TYPE_B: begin
                raw = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
                bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            end
            INSTR_TYPE_U: begin
                raw = {imm[31:12], rd, opcode};
                bad = |imm[11:0];
            end
            INSTR_TYPE_J: begin
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            end
            default: begin
                raw = NOP_INSTR;
                bad = 1'b1;
            end
        endcase
    end

    assign word = bad ? NOP_INSTR : raw;
    assign err  = bad;

endmodule

// File: rtl/instruction_encode.sv
// rtl/instruction_encode.sv - valid/ready RV32I encoder with output stage, skid register and counters
module instruction_encode
    import instruction_encode_pkg::*;
#(
    parameter int CNT_WIDTH     = 16,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    instruction_encode_if.slave      bus,
    output logic [CNT_WIDTH-1:0]     enc_count,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    logic [INSTR_WIDTH-1:0] enc_word;
    logic                   enc_err;

    instr_field_pack u_pack (
        .opcode (bus.in_opcode),
        .rd     (bus.in_rd),
        .rs1    (bus.in_rs1),
        .rs2    (bus.in_rs2),
        .func3  (bus.in_func3),
        .func7  (bus.in_func7),
        .imm    (bus.in_imm),
        .word   (enc_word),
        .err    (enc_err)
    );

    fill_state_t            state;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [INSTR_WIDTH-1:0] out_instr_q;
    logic                   out_err_q;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic                   skid_err;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = bus.in_valid && in_ready_q;
    assign out_xfer = out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_err   = out_err_q;

    // in_ready is registered as (next state != TWO), so it never depends on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_err_q   <= 1'b0;
            skid_instr  <= '0;
            skid_err    <= 1'b0;
            enc_count   <= '0;
            err_count   <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        out_instr_q <= enc_word;
                        out_err_q   <= enc_err;
                        out_valid_q <= 1'b1;
                        state       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        skid_instr <= enc_word;
                        skid_err   <= enc_err;
                        in_ready_q <= 1'b0;
                        state      <= ST_TWO;
                    end else if (in_xfer) begin
                        out_instr_q <= enc_word;
                        out_err_q   <= enc_err;
                    end else if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        out_instr_q <= skid_instr;
                        out_err_q   <= skid_err;
                        in_ready_q  <= 1'b1;
                        state       <= ST_ONE;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase

            if (in_xfer) begin
                enc_count <= enc_count + 1'b1;
                if (enc_err && !(&err_count)) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_encode.sv
// tb/tb_instruction_encode.sv - scoreboard bench with randomized fields and a range-based reference encoder
module tb_instruction_encode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    instruction_encode_if bus();

    instruction_encode #(.CNT_WIDTH(16), .ERR_CNT_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_enc  = 0;
    int   exp_err  = 0;
    bit   rand_ready = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %08h required %08h", name, act, req);
    endtask

    // Reference encoder: ranges as signed integers, fields placed by shift arithmetic.
    function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] imm, output logic [31:0] w, output logic e);
        int          s;
        bit          ok;
        logic [31:0] base;
        s    = $signed(imm);
        ok   = 0;
        w    = 32'h13;
        base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (op)
            7'b0000011, 7'b1100111, 7'b0010011: begin
                if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    ok = (imm < 32) && ((f3 == 3'd1) ? (f7 == 0) : (f7 == 0 || f7 == 7'h20));
                    w  = (32'(f7) << 25) | ((imm % 32) << 20) | base | (32'(rd) << 7);
                end else begin
                    ok = (s >= -2048) && (s <= 2047);
                    w  = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7);
                end
            end
            7'b0100011: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1F) << 7);
            end
            7'b1100011: begin
                ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
                w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) | base
                   | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
            end
            7'b0110011: begin
                ok = (f7 == 0) || (f7 == 7'h20);
                w  = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
            end
            7'b0110111, 7'b0010111: begin
                ok = (imm % 4096 == 0);
                w  = imm | (32'(rd) << 7) | 32'(op);
            end
            7'b1101111: begin
                ok = (s >= -(1 << 20)) && (s < (1 << 20)) && (s % 2 == 0);
                w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                   | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
            end
            default: ok = 0;
        endcase
        e = !ok;
        if (!ok) w = 32'h13;
    endfunction

    task automatic send_exp(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                            input logic [31:0] w, input logic e);
        exp_t x;
        int   n = 0;
        x.w = w;
        x.e = e;
        exp_q.push_back(x);
        bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_func3 = f3; bus.in_func7 = f7; bus.in_imm = imm;
        @(negedge clk);
        while (!bus.in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        exp_enc = exp_enc + 1;
        if (e && exp_err < 255) exp_err = exp_err + 1;
    endtask

    task automatic send_model(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        logic        e;
        ref_encode(op, rd, rs1, rs2, f3, f7, imm, w, e);
        send_exp(op, rd, rs1, rs2, f3, f7, imm, w, e);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", bus.out_instr, 32'hxxxxxxxx);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("out_instr", bus.out_instr, x.w);
                check("out_err", 32'(bus.out_err), 32'(x.e));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    logic [6:0] op_tab [10] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b0110011,
                                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0010011};

    initial begin
        bus.in_valid = 0; bus.in_opcode = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
        bus.in_func3 = 0; bus.in_func7 = 0; bus.in_imm = 0; bus.out_ready = 1;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_out_err", 32'(bus.out_err), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_enc_count", 32'(enc_count), 0);
        check("rst_err_count", 32'(err_count), 0);
        @(posedge clk); #3; rst = 0;
        @(posedge clk); #1;

        send_exp(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h00500093, 1'b0);
        check("latency_one_cycle", 32'(bus.out_valid), 1);
        send_exp(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h402081B3, 1'b0);
        send_exp(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3, 1'b0);
        send_exp(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
        send_exp(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8, 32'h008000EF, 1'b0);
        send_exp(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0);
        send_exp(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, 32'h00000013, 1'b1);
        send_exp(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3, 32'h00000013, 1'b1);
        send_exp(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0, 32'h00000013, 1'b1);
        drain();
        check("directed_enc_count", 32'(enc_count), 32'd9);
        check("directed_err_count", 32'(err_count), 32'd3);

        bus.out_ready = 0;
        send_exp(7'b0010011, 5'd7, 5'd8, 5'd0, 3'd0, 7'h00, 32'd100, 32'h06440393, 1'b0);
        send_exp(7'b0110011, 5'd9, 5'd10, 5'd11, 3'd0, 7'h00, 32'd0, 32'h00B504B3, 1'b0);
        check("bp_in_ready_low", 32'(bus.in_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_valid", 32'(bus.out_valid), 1);
        check("bp_hold_instr", bus.out_instr, 32'h06440393);
        bus.out_ready = 1;
        @(posedge clk); #1;
        check("bp_in_ready_back", 32'(bus.in_ready), 1);
        drain();

        rand_ready = 1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] imm;
            logic [6:0]  f7;
            logic [6:0]  op;
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
                2: imm = $urandom & 32'hFFFFF000;
                default: imm = 32'($urandom_range(0, 40));
            endcase
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_tab[$urandom_range(0, 9)];
            send_model(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), f7, imm);
        end
        rand_ready = 0;
        @(posedge clk); #1;
        bus.out_ready = 1;
        drain();
        check("rand_enc_count", 32'(enc_count), 32'(exp_enc & 16'hFFFF));
        check("rand_err_count", 32'(err_count), 32'(exp_err));

        bus.out_ready = 0;
        send_model(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'd1);
        send_model(7'b0010011, 5'd2, 5'd3, 5'd0, 3'd0, 7'h00, 32'd2);
        #3;
        rst = 1;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 1);
        check("mid_rst_enc_count", 32'(enc_count), 0);
        check("mid_rst_err_count", 32'(err_count), 0);
        exp_q.delete();
        exp_enc = 0;
        exp_err = 0;
        bus.out_ready = 1;
        @(posedge clk); #3; rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 256; i++) begin
            send_exp(7'h7F, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), $urandom,
                     32'h00000013, 1'b1);
        end
        drain();
        check("sat_err_count", 32'(err_count), 32'h000000FF);
        check("sat_enc_count", 32'(enc_count), 32'd256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule
